// File: rtl/bcd_ctrl.sv
// Double-dabble sequencer: drives LOAD / per-digit ADD3 / SHIFT pulses to a binary-to-BCD datapath.
// Optional `BCD_CTRL_SKIP3_EN skips the digit check on the first three iterations after LOAD.
module bcd_ctrl #(
  parameter int N_BITS = 16,
  parameter int N_DIG  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  input  logic [N_DIG-1:0]              in_GE5,
  output logic                          out_LOAD,
  output logic [N_DIG-1:0]              out_ADD3,
  output logic                          out_SHIFT,
  output logic [$clog2(N_BITS+1)-1:0]   out_CNT,
  output logic                          out_BUSY,
  output logic                          out_DONE
);

  localparam int CW = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [N_DIG-1:0] mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init) state_nxt = S_LOAD;
`ifdef BCD_CTRL_SKIP3_EN
      S_LOAD:  state_nxt = S_SHIFT;
`else
      S_LOAD:  state_nxt = S_CHECK;
`endif
      S_CHECK: state_nxt = (|in_GE5) ? S_ADD : S_SHIFT;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (cnt <= CW'(1))
          state_nxt = S_DONE;
`ifdef BCD_CTRL_SKIP3_EN
        // counts N_BITS and N_BITS-1 are the first two shifts; no digit can be >= 5 yet
        else if (cnt > CW'(N_BITS - 2))
          state_nxt = S_SHIFT;
`endif
        else
          state_nxt = S_CHECK;
      end
      S_DONE:  if (!init) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      mask <= '0;
    end else begin
      case (state)
        S_LOAD:  cnt  <= CW'(N_BITS);
        S_CHECK: mask <= in_GE5;
        S_SHIFT: if (cnt != '0) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    out_LOAD  = 1'b0;
    out_ADD3  = '0;
    out_SHIFT = 1'b0;
    out_DONE  = 1'b0;
    out_BUSY  = 1'b1;
    out_CNT   = cnt;
    case (state)
      S_IDLE:  out_BUSY  = 1'b0;
      S_LOAD:  out_LOAD  = 1'b1;
      S_ADD:   out_ADD3  = mask;
      S_SHIFT: out_SHIFT = 1'b1;
      S_DONE: begin
        out_BUSY = 1'b0;
        out_DONE = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd_ctrl.sv
// Bench for bcd_ctrl: behavioural double-dabble datapath around the controller, scoreboarded conversions.
module tb_bcd_ctrl;

  localparam int NB = 16;
  localparam int ND = 4;
  localparam int CW = $clog2(NB + 1);
`ifdef BCD_CTRL_SKIP3_EN
  localparam int BASE_LAT = 2 + 2 * NB - 3;
`else
  localparam int BASE_LAT = 2 + 2 * NB;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          init;
  logic [ND-1:0] in_GE5;
  logic          out_LOAD;
  logic [ND-1:0] out_ADD3;
  logic          out_SHIFT;
  logic [CW-1:0] out_CNT;
  logic          out_BUSY;
  logic          out_DONE;

  bcd_ctrl #(.N_BITS(NB), .N_DIG(ND)) dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .in_GE5   (in_GE5),
    .out_LOAD (out_LOAD),
    .out_ADD3 (out_ADD3),
    .out_SHIFT(out_SHIFT),
    .out_CNT  (out_CNT),
    .out_BUSY (out_BUSY),
    .out_DONE (out_DONE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Datapath model: binary register plus four BCD digits in one shift chain
  logic [15:0]   bin_in;
  logic [15:0]   dp_bin;
  logic [15:0]   dp_bcd;
  logic          force_en;
  logic [ND-1:0] force_val;
  logic [ND-1:0] ge5;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_bin <= '0;
      dp_bcd <= '0;
    end else if (out_LOAD) begin
      dp_bin <= bin_in;
      dp_bcd <= '0;
    end else if (|out_ADD3) begin
      for (int i = 0; i < ND; i++)
        if (out_ADD3[i]) dp_bcd[4*i +: 4] <= dp_bcd[4*i +: 4] + 4'd3;
    end else if (out_SHIFT) begin
      {dp_bcd, dp_bin} <= {dp_bcd[14:0], dp_bin, 1'b0};
    end
  end

  always_comb begin
    ge5 = '0;
    for (int i = 0; i < ND; i++) ge5[i] = (dp_bcd[4*i +: 4] >= 4'd5);
    in_GE5 = force_en ? force_val : ge5;
  end

  // Reference count of iterations needing an add-3 for a given input
  function automatic int ref_adds(input logic [15:0] b);
    logic [31:0] sr;
    int a;
    logic any;
    sr = {16'd0, b};
    a  = 0;
    for (int it = 0; it < NB; it++) begin
      any = 1'b0;
      for (int i = 0; i < ND; i++) begin
        if (sr[16 + 4*i +: 4] >= 4'd5) begin
          sr[16 + 4*i +: 4] = sr[16 + 4*i +: 4] + 4'd3;
          any = 1'b1;
        end
      end
      if (any) a++;
      sr = sr << 1;
    end
    return a;
  endfunction

  typedef struct {
    int start;
    int lat;
    int adds;
    int dig[4];
  } exp_t;

  exp_t sb[$];

  int loads  = 0;
  int adds   = 0;
  int shifts = 0;
  logic load_q = 1'b0;
  logic done_q = 1'b0;

  // Monitor: per-cycle pulse exclusivity, counter start value, scoreboard pop at DONE
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        load_q = 1'b0;
        done_q = 1'b0;
      end else begin
        chk("pulse_excl", int'(out_LOAD) + int'(|out_ADD3) + int'(out_SHIFT) <= 1, 1);
        if (load_q) chk("cnt_after_load", int'(out_CNT), NB);
        if (out_LOAD) begin
          loads++;
          adds   = 0;
          shifts = 0;
        end
        if (|out_ADD3) adds++;
        if (out_SHIFT) shifts++;
        if (out_DONE && !done_q) begin
          if (sb.size() == 0) begin
            chk("sb_empty_at_done", 0, 1);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - e.start, e.lat);
            chk("add_cycles", adds, e.adds);
            chk("shift_pulses", shifts, NB);
            for (int i = 0; i < ND; i++) chk("digit", int'(dp_bcd[4*i +: 4]), e.dig[i]);
            chk("cnt_done", int'(out_CNT), 0);
            chk("busy_done", int'(out_BUSY), 0);
          end
        end
        load_q = out_LOAD;
        done_q = out_DONE;
      end
    end
  end

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_DONE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run_conv(input logic [15:0] b, input logic hold, input logic glitch);
    exp_t e;
    logic ok;
    int   l0;
    int   v;
    @(negedge clk);
    bin_in = b;
    init   = 1'b1;
    e.start = cyc;
    e.adds  = ref_adds(b);
    e.lat   = BASE_LAT + e.adds;
    v = int'(b);
    for (int i = 0; i < 4; i++) begin
      e.dig[i] = v % 10;
      v = v / 10;
    end
    sb.push_back(e);
    @(negedge clk);
    init = 1'b0;
    if (glitch) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        init = 1'($urandom_range(0, 1));
      end
      init = 1'b0;
    end
    wait_done(ok);
    if (ok) begin
      if (hold) begin
        init = 1'b1;
        l0 = loads;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("done_held", int'(out_DONE), 1);
        end
        chk("no_reload", loads, l0);
        init = 1'b0;
        @(negedge clk);
        chk("idle_after_drop", int'(out_DONE), 0);
        chk("busy_after_drop", int'(out_BUSY), 0);
      end else begin
        @(negedge clk);
        chk("done_one_cycle", int'(out_DONE), 0);
      end
    end
  endtask

  logic found;

  initial begin
    rst       = 1'b1;
    init      = 1'b0;
    bin_in    = '0;
    force_en  = 1'b0;
    force_val = '0;
    repeat (2) @(negedge clk);
    chk("rst_load", int'(out_LOAD), 0);
    chk("rst_add3", int'(out_ADD3), 0);
    chk("rst_shift", int'(out_SHIFT), 0);
    chk("rst_cnt", int'(out_CNT), 0);
    chk("rst_busy", int'(out_BUSY), 0);
    chk("rst_done", int'(out_DONE), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_conv(16'd0, 1'b0, 1'b0);
    run_conv(16'd255, 1'b0, 1'b0);
    run_conv(16'd9999, 1'b0, 1'b0);
    run_conv(16'd1234, 1'b1, 1'b0);
    run_conv(16'd4095, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) run_conv(16'($urandom_range(0, 9999)), 1'b0, 1'b0);

    // Directed add-3 mask, then asynchronous reset mid-conversion
    @(negedge clk);
    bin_in = 16'd0;
    init   = 1'b1;
    @(negedge clk);
    init  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_BUSY && !out_LOAD && !out_SHIFT && out_ADD3 == '0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("check_state_found", int'(found), 1);
    force_en  = 1'b1;
    force_val = 4'b1010;
    @(negedge clk);
    chk("mask_add3", int'(out_ADD3), 4'b1010);
    chk("mask_no_shift", int'(out_SHIFT), 0);
    force_en = 1'b0;
    @(negedge clk);
    chk("mask_add3_gone", int'(out_ADD3), 0);
    chk("mask_then_shift", int'(out_SHIFT), 1);

    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_CNT == CW'(9)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cnt9_found", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("arst_load", int'(out_LOAD), 0);
    chk("arst_add3", int'(out_ADD3), 0);
    chk("arst_shift", int'(out_SHIFT), 0);
    chk("arst_cnt", int'(out_CNT), 0);
    chk("arst_busy", int'(out_BUSY), 0);
    chk("arst_done", int'(out_DONE), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_rst", int'(out_BUSY) + int'(out_LOAD) + int'(out_DONE), 0);
    end

    run_conv(16'd8765, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_ctrl.md
BCD_CTRL -- requirements
Module: bcd_ctrl

Interface
REQ-001 Parameter: N_BITS, default 16, number of shift iterations per conversion (binary input width of the datapath).
REQ-002 Parameter: N_DIG, default 4, number of BCD digits driven (UND, DEC, CEN, K).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: init  input  1  start request; level-sensitive, sampled only in IDLE and DONE.
REQ-006 Port: in_GE5  input  N_DIG  per-digit flag from datapath, 1 = digit value >= 5 (bit0 = UND ... bit3 = K).
REQ-007 Port: out_LOAD  output  1  one-cycle pulse; datapath loads in_BIN and clears digits.
REQ-008 Port: out_ADD3  output  N_DIG  one-cycle per-digit add-3 enable.
REQ-009 Port: out_SHIFT  output  1  one-cycle pulse; datapath shifts the digit/binary chain left by one.
REQ-010 Port: out_CNT  output  clog2(N_BITS+1)  remaining shift iterations.
REQ-011 Port: out_BUSY  output  1  high in every state except IDLE and DONE.
REQ-012 Port: out_DONE  output  1  high while in DONE.

Function
REQ-013 FSM states: IDLE, LOAD, CHECK, ADD, SHIFT, DONE; all outputs decoded from registered state/mask/counter (no combinational path from inputs to outputs).
REQ-014 IDLE: init=1 -> LOAD; else stay.
REQ-015 LOAD: out_LOAD=1, counter <= N_BITS; next state CHECK.
REQ-016 CHECK: mask register <= in_GE5; if in_GE5 != 0 -> ADD, else -> SHIFT; no output pulses.
REQ-017 ADD: out_ADD3 = mask register for exactly this cycle; next state SHIFT.
REQ-018 SHIFT: out_SHIFT=1, counter decrements by 1; if counter was 1 -> DONE, else -> CHECK.
REQ-019 DONE: out_DONE=1; stay while init=1; init=0 -> IDLE (full four-phase handshake; no auto-restart on held init).
REQ-020 init asserted/changed in LOAD, CHECK, ADD, SHIFT is ignored; no restart or abort.
REQ-021 Latency: init sampled high in IDLE at cycle n -> out_DONE first high at cycle n+2+2*N_BITS+A, A = number of ADD cycles.
REQ-022 out_LOAD, out_ADD3, out_SHIFT never asserted in the same cycle; out_ADD3 only nonzero in ADD.
REQ-023 Counter never wraps: decrements only in SHIFT with counter >= 1; holds value 0 in DONE/IDLE.

Reset
REQ-024 rst=1 forces state IDLE, counter 0, mask 0, all outputs 0 immediately (asynchronously), including mid-conversion.
REQ-025 After rst deasserts, first conversion requires a fresh init sample in IDLE; partial conversion is discarded.

Configuration
REQ-026 Macro BCD_CTRL_SKIP3_EN: when defined, the first 3 iterations after LOAD go directly LOAD->SHIFT->SHIFT->SHIFT (no CHECK/ADD, since no digit can reach 5 before 3 shifts), then normal CHECK/ADD/SHIFT; latency becomes n+2+2*N_BITS-3+A.
REQ-027 Without BCD_CTRL_SKIP3_EN every iteration, including the first 3, passes through CHECK.

Verification
REQ-028 in_GE5 tied 0, init pulse at cycle 0 -> out_LOAD at 1, 16 out_SHIFT pulses, out_DONE at cycle 34, out_ADD3 always 0.
REQ-029 Datapath model with in_BIN=255 -> digits U=5,D=5,C=2 at DONE; add cycles counted match latency formula.
REQ-030 in_GE5=4'b1010 sampled in CHECK -> next cycle out_ADD3=4'b1010 for one cycle, then out_SHIFT.
REQ-031 init held high through DONE -> out_DONE stays 1, no second out_LOAD; init dropped -> IDLE next cycle.
REQ-032 rst asserted with out_CNT=9 -> all outputs 0 same cycle, out_CNT=0, IDLE after release.
REQ-033 BCD_CTRL_SKIP3_EN defined, in_GE5=0 -> out_DONE at cycle 31.
